// File: rtl/instr_refill_arbiter.sv
// Round-robin arbiter sharing one instruction-refill read adapter between NUM_REQ requesters.
// The requester index is packed into the ID MSBs and read beats are routed back by that index.
module instr_refill_arbiter #(
   parameter int unsigned NUM_REQ          = 2,
   parameter int unsigned FETCH_ADDR_WIDTH = 34,
   parameter int unsigned FETCH_DATA_WIDTH = 32,
   parameter int unsigned ID_WIDTH         = 4,
   parameter int unsigned IDX_WIDTH        = $clog2(NUM_REQ),
   parameter int unsigned LOCAL_ID_WIDTH   = ID_WIDTH - IDX_WIDTH,
   parameter int unsigned MAX_OUTSTANDING  = 4
) (
   input  logic                                       clk_i,
   input  logic                                       rst_ni,
   input  logic [NUM_REQ-1:0]                         req_i,
   input  logic [NUM_REQ-1:0]                         type_i,
   input  logic [NUM_REQ-1:0][FETCH_ADDR_WIDTH-1:0]   addr_i,
   input  logic [NUM_REQ-1:0][LOCAL_ID_WIDTH-1:0]     id_i,
   output logic [NUM_REQ-1:0]                         gnt_o,
   output logic [NUM_REQ-1:0]                         r_valid_o,
   output logic [FETCH_DATA_WIDTH-1:0]                r_data_o,
   output logic                                       r_last_o,
   output logic [LOCAL_ID_WIDTH-1:0]                  r_id_o,
   output logic                                       refill_req_o,
   output logic                                       refill_type_o,
   output logic [FETCH_ADDR_WIDTH-1:0]                refill_addr_o,
   output logic [ID_WIDTH-1:0]                        refill_ID_o,
   input  logic                                       refill_gnt_i,
   input  logic                                       refill_r_valid_i,
   input  logic [FETCH_DATA_WIDTH-1:0]                refill_r_data_i,
   input  logic                                       refill_r_last_i,
   input  logic [ID_WIDTH-1:0]                        refill_r_ID_i
);

   localparam int unsigned            CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_WIDTH-1:0]   CNT_MAX   = CNT_WIDTH'(MAX_OUTSTANDING);
   localparam logic [CNT_WIDTH-1:0]   CNT_ONE   = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0]   CNT_ZERO  = CNT_WIDTH'(0);
   localparam logic [IDX_WIDTH-1:0]   IDX_LAST  = IDX_WIDTH'(NUM_REQ - 1);
   localparam logic [IDX_WIDTH-1:0]   IDX_ONE   = IDX_WIDTH'(1);
   localparam logic [IDX_WIDTH-1:0]   IDX_ZERO  = IDX_WIDTH'(0);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } state_e;

   state_e                      r_state;
   state_e                      w_state_nxt;
   logic [IDX_WIDTH-1:0]        r_rr_ptr;
   logic [IDX_WIDTH-1:0]        r_sel;
   logic [CNT_WIDTH-1:0]        r_count;
   logic [CNT_WIDTH-1:0]        w_count_nxt;
   logic [FETCH_ADDR_WIDTH-1:0] r_addr;
   logic                        r_type;
   logic [ID_WIDTH-1:0]         r_id;
   logic [IDX_WIDTH-1:0]        w_win;
   logic [IDX_WIDTH-1:0]        w_scan;
   logic                        w_found;
   logic                        w_hit;
   logic                        w_can_issue;
   logic                        w_select;
   logic                        w_grant;
   logic                        w_last_beat;
   logic [IDX_WIDTH-1:0]        w_r_idx;

   function automatic logic [IDX_WIDTH-1:0] idx_inc(input logic [IDX_WIDTH-1:0] idx);
      idx_inc = (idx == IDX_LAST) ? IDX_ZERO : idx + IDX_ONE;
   endfunction

   // Round-robin scan: first requester at or after r_rr_ptr wins.
   always_comb begin
      w_win   = r_rr_ptr;
      w_scan  = r_rr_ptr;
      w_found = 1'b0;
      w_hit   = 1'b0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         w_hit   = ~w_found & req_i[w_scan];
         w_win   = w_hit ? w_scan : w_win;
         w_found = w_found | w_hit;
         w_scan  = idx_inc(w_scan);
      end
   end

   assign w_can_issue = (|req_i) & (r_count < CNT_MAX);
   assign w_select    = (r_state == ST_IDLE) & w_can_issue;
   assign w_grant     = (r_state == ST_ISSUE) & refill_gnt_i;
   assign w_last_beat = refill_r_valid_i & refill_r_last_i;
   assign w_r_idx     = refill_r_ID_i[ID_WIDTH-1 -: IDX_WIDTH];

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_can_issue) w_state_nxt = ST_ISSUE;
            else             w_state_nxt = ST_IDLE;
         end
         ST_ISSUE: begin
            if (refill_gnt_i) w_state_nxt = ST_IDLE;
            else              w_state_nxt = ST_ISSUE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Simultaneous issue and retire cancel out; a lone retire saturates at zero.
   always_comb begin
      w_count_nxt = r_count;
      case ({w_grant, w_last_beat})
         2'b10:   w_count_nxt = r_count + CNT_ONE;
         2'b01:   w_count_nxt = (r_count != CNT_ZERO) ? r_count - CNT_ONE : CNT_ZERO;
         default: w_count_nxt = r_count;
      endcase
   end

   // Selection latch, round-robin pointer and outstanding-burst counter.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rr_ptr <= IDX_ZERO;
         r_sel    <= IDX_ZERO;
         r_count  <= CNT_ZERO;
         r_addr   <= {FETCH_ADDR_WIDTH{1'b0}};
         r_type   <= 1'b0;
         r_id     <= {ID_WIDTH{1'b0}};
      end else begin
         r_count <= w_count_nxt;
         if (w_select) begin
            r_sel  <= w_win;
            r_addr <= addr_i[w_win];
            r_type <= type_i[w_win];
            r_id   <= {w_win, id_i[w_win]};
         end
         if (w_grant) begin
            r_rr_ptr <= idx_inc(r_sel);
         end
      end
   end

   // Request drops in the grant cycle so the adapter never sees a duplicate AR.
   always_comb begin
      refill_req_o  = (r_state == ST_ISSUE) & ~refill_gnt_i;
      refill_type_o = r_type;
      refill_addr_o = r_addr;
      refill_ID_o   = r_id;
      gnt_o         = {NUM_REQ{1'b0}};
      r_valid_o     = {NUM_REQ{1'b0}};
      for (int k = 0; k < int'(NUM_REQ); k++) begin
         gnt_o[k]     = w_grant & (r_sel == IDX_WIDTH'(k));
         r_valid_o[k] = refill_r_valid_i & (w_r_idx == IDX_WIDTH'(k));
      end
      r_data_o = refill_r_data_i;
      r_last_o = refill_r_last_i;
      r_id_o   = refill_r_ID_i[LOCAL_ID_WIDTH-1:0];
   end

endmodule

// File: tb/tb_instr_refill_arbiter.sv
// Self-checking bench for instr_refill_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level reference model.
module tb_instr_refill_arbiter;

   localparam int NR = 2;
   localparam int AW = 34;
   localparam int DW = 32;
   localparam int IW = 4;
   localparam int LW = 3;
   localparam int MO = 4;

   logic                   clk = 1'b0;
   logic                   rst_ni;
   logic [NR-1:0]          req_i, type_i;
   logic [NR-1:0][AW-1:0]  addr_i;
   logic [NR-1:0][LW-1:0]  id_i;
   logic [NR-1:0]          gnt_o, r_valid_o;
   logic [DW-1:0]          r_data_o;
   logic                   r_last_o;
   logic [LW-1:0]          r_id_o;
   logic                   refill_req_o, refill_type_o;
   logic [AW-1:0]          refill_addr_o;
   logic [IW-1:0]          refill_ID_o;
   logic                   refill_gnt_i, refill_r_valid_i, refill_r_last_i;
   logic [DW-1:0]          refill_r_data_i;
   logic [IW-1:0]          refill_r_ID_i;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   instr_refill_arbiter #(
      .NUM_REQ(NR), .FETCH_ADDR_WIDTH(AW), .FETCH_DATA_WIDTH(DW),
      .ID_WIDTH(IW), .MAX_OUTSTANDING(MO)
   ) dut (
      .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .type_i(type_i),
      .addr_i(addr_i), .id_i(id_i), .gnt_o(gnt_o), .r_valid_o(r_valid_o),
      .r_data_o(r_data_o), .r_last_o(r_last_o), .r_id_o(r_id_o),
      .refill_req_o(refill_req_o), .refill_type_o(refill_type_o),
      .refill_addr_o(refill_addr_o), .refill_ID_o(refill_ID_o),
      .refill_gnt_i(refill_gnt_i), .refill_r_valid_i(refill_r_valid_i),
      .refill_r_data_i(refill_r_data_i), .refill_r_last_i(refill_r_last_i),
      .refill_r_ID_i(refill_r_ID_i)
   );

   task automatic clk_wait();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      req_i = '0; type_i = '0; addr_i = '0; id_i = '0;
      refill_gnt_i = 1'b0; refill_r_valid_i = 1'b0; refill_r_last_i = 1'b0;
      refill_r_data_i = '0; refill_r_ID_i = '0;
   endtask

   task automatic apply_reset();
      drive_idle();
      rst_ni = 1'b0;
      clk_wait();
      clk_wait();
      rst_ni = 1'b1;
   endtask

   // Counts gnt_o pulses over n cycles with the current stimulus held.
   task automatic count_grants(input int n, output int g0, output int g1);
      g0 = 0; g1 = 0;
      for (int i = 0; i < n; i++) begin
         #1;
         if (gnt_o[0]) g0++;
         if (gnt_o[1]) g1++;
         clk_wait();
      end
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      req_i = 2'b11; refill_gnt_i = 1'b1;
      refill_r_valid_i = 1'b1; refill_r_last_i = 1'b1;
      refill_r_ID_i = 4'b1010; refill_r_data_i = 32'hA5A5_0001;
      clk_wait();
      #1;
      n_cmp++; if (refill_req_o !== 1'b0) begin n_err++; $display("FAIL reset_req: got %0b want 0", refill_req_o); end
      n_cmp++; if (gnt_o !== 2'b00) begin n_err++; $display("FAIL reset_gnt: got %b want 00", gnt_o); end
      n_cmp++; if (refill_addr_o !== 34'h0) begin n_err++; $display("FAIL reset_addr: got %0h want 0", refill_addr_o); end
      n_cmp++; if (refill_ID_o !== 4'h0) begin n_err++; $display("FAIL reset_id: got %0h want 0", refill_ID_o); end
      n_cmp++; if (refill_type_o !== 1'b0) begin n_err++; $display("FAIL reset_type: got %0b want 0", refill_type_o); end
      n_cmp++; if (r_valid_o !== 2'b10) begin n_err++; $display("FAIL reset_route: got %b want 10", r_valid_o); end
      n_cmp++; if (r_id_o !== 3'b010) begin n_err++; $display("FAIL reset_rid: got %0h want 2", r_id_o); end
      n_cmp++; if (r_data_o !== 32'hA5A5_0001) begin n_err++; $display("FAIL reset_rdata: got %0h want a5a50001", r_data_o); end
      drive_idle();
      #1;
      n_cmp++; if (r_valid_o !== 2'b00 || r_last_o !== 1'b0 || r_data_o !== 32'h0) begin
         n_err++; $display("FAIL reset_r_zero: got v=%b l=%b d=%0h want 0", r_valid_o, r_last_o, r_data_o); end
   endtask

   task automatic test_single();
      apply_reset();
      req_i = 2'b01; type_i = 2'b00; addr_i[0] = 34'h1000; id_i[0] = 3'd3;
      #1;
      n_cmp++; if (refill_req_o !== 1'b0) begin n_err++; $display("FAIL single_c0_req: got %0b want 0", refill_req_o); end
      clk_wait();
      #1;
      n_cmp++; if (refill_req_o !== 1'b1) begin n_err++; $display("FAIL single_c1_req: got %0b want 1", refill_req_o); end
      n_cmp++; if (refill_ID_o !== 4'b0011) begin n_err++; $display("FAIL single_id: got %b want 0011", refill_ID_o); end
      n_cmp++; if (refill_addr_o !== 34'h1000) begin n_err++; $display("FAIL single_addr: got %0h want 1000", refill_addr_o); end
      n_cmp++; if (gnt_o !== 2'b00) begin n_err++; $display("FAIL single_c1_gnt: got %b want 00", gnt_o); end
      clk_wait();
      refill_gnt_i = 1'b1;
      #1;
      n_cmp++; if (refill_req_o !== 1'b0) begin n_err++; $display("FAIL single_c2_req: got %0b want 0", refill_req_o); end
      n_cmp++; if (gnt_o !== 2'b01) begin n_err++; $display("FAIL single_c2_gnt: got %b want 01", gnt_o); end
      clk_wait();
      refill_gnt_i = 1'b0; req_i = 2'b00;
      refill_r_valid_i = 1'b1; refill_r_last_i = 1'b1; refill_r_ID_i = 4'h3; refill_r_data_i = 32'hCAFE_0003;
      #1;
      n_cmp++; if (gnt_o !== 2'b00 || refill_req_o !== 1'b0) begin n_err++; $display("FAIL single_c3_idle: got gnt=%b req=%b want 00/0", gnt_o, refill_req_o); end
      n_cmp++; if (r_valid_o !== 2'b01) begin n_err++; $display("FAIL single_route: got %b want 01", r_valid_o); end
      n_cmp++; if (r_id_o !== 3'd3 || r_last_o !== 1'b1) begin n_err++; $display("FAIL single_rid: got id=%0d last=%b want 3/1", r_id_o, r_last_o); end
      clk_wait();
      drive_idle();
   endtask

   task automatic test_rr_alternate();
      logic [1:0] exp_g;
      apply_reset();
      id_i[0] = 3'd2; id_i[1] = 3'd6;
      addr_i[0] = 34'h0_1111_0000; addr_i[1] = 34'h2_2222_0000;
      req_i = 2'b11; refill_gnt_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         #1;
         exp_g = ((i % 2 == 1) && i < 8) ? ((i % 4 == 1) ? 2'b01 : 2'b10) : 2'b00;
         n_cmp++; if (gnt_o !== exp_g) begin n_err++; $display("FAIL rr_gnt c%0d: got %b want %b", i, gnt_o, exp_g); end
         if (exp_g == 2'b10) begin
            n_cmp++; if (refill_ID_o !== 4'b1110 || refill_addr_o !== 34'h2_2222_0000) begin
               n_err++; $display("FAIL rr_id1 c%0d: got id=%b addr=%0h want 1110/222220000", i, refill_ID_o, refill_addr_o); end
         end
         if (exp_g == 2'b01) begin
            n_cmp++; if (refill_ID_o !== 4'b0010 || refill_addr_o !== 34'h0_1111_0000) begin
               n_err++; $display("FAIL rr_id0 c%0d: got id=%b addr=%0h want 0010/011110000", i, refill_ID_o, refill_addr_o); end
         end
         clk_wait();
      end
   endtask

   // Runs straight after test_rr_alternate with four bursts outstanding.
   task automatic test_full_throttle();
      refill_gnt_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_cmp++; if (refill_req_o !== 1'b0) begin n_err++; $display("FAIL full_hold c%0d: got %b want 0", i, refill_req_o); end
         clk_wait();
      end
      refill_r_valid_i = 1'b1; refill_r_last_i = 1'b1; refill_r_ID_i = 4'h0;
      #1;
      n_cmp++; if (refill_req_o !== 1'b0) begin n_err++; $display("FAIL full_L0: got %b want 0", refill_req_o); end
      clk_wait();
      refill_r_valid_i = 1'b0; refill_r_last_i = 1'b0;
      #1;
      n_cmp++; if (refill_req_o !== 1'b0) begin n_err++; $display("FAIL full_L1: got %b want 0", refill_req_o); end
      clk_wait();
      #1;
      n_cmp++; if (refill_req_o !== 1'b1 || refill_ID_o !== 4'b0010) begin
         n_err++; $display("FAIL full_L2: got req=%b id=%b want 1/0010", refill_req_o, refill_ID_o); end
      refill_gnt_i = 1'b1;
      #1;
      n_cmp++; if (gnt_o !== 2'b01 || refill_req_o !== 1'b0) begin
         n_err++; $display("FAIL full_5th_gnt: got gnt=%b req=%b want 01/0", gnt_o, refill_req_o); end
      clk_wait();
      refill_gnt_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++; if (refill_req_o !== 1'b0) begin n_err++; $display("FAIL full_again c%0d: got %b want 0", i, refill_req_o); end
         clk_wait();
      end
   endtask

   task automatic test_type1_routing();
      int g0, g1;
      apply_reset();
      req_i = 2'b10; type_i = 2'b10; id_i[1] = 3'd5; addr_i[1] = 34'h3_0000_0040;
      clk_wait();
      #1;
      n_cmp++; if (refill_req_o !== 1'b1 || refill_type_o !== 1'b1 || refill_ID_o !== 4'b1101 || refill_addr_o !== 34'h3_0000_0040) begin
         n_err++; $display("FAIL t1_issue: got req=%b type=%b id=%b addr=%0h want 1/1/1101/300000040",
                           refill_req_o, refill_type_o, refill_ID_o, refill_addr_o); end
      refill_gnt_i = 1'b1;
      #1;
      n_cmp++; if (gnt_o !== 2'b10) begin n_err++; $display("FAIL t1_gnt: got %b want 10", gnt_o); end
      clk_wait();
      refill_gnt_i = 1'b0; req_i = 2'b01; type_i = 2'b00; id_i[0] = 3'd1; addr_i[0] = 34'h80;
      clk_wait();
      refill_gnt_i = 1'b1;
      #1;
      n_cmp++; if (gnt_o !== 2'b01 || refill_type_o !== 1'b0) begin n_err++; $display("FAIL t1_gnt0: got gnt=%b type=%b want 01/0", gnt_o, refill_type_o); end
      clk_wait();
      refill_gnt_i = 1'b0; req_i = 2'b00;
      refill_r_valid_i = 1'b1; refill_r_last_i = 1'b0; refill_r_ID_i = 4'b1101; refill_r_data_i = 32'h1111_1111;
      #1;
      n_cmp++; if (r_valid_o !== 2'b10 || r_last_o !== 1'b0 || r_id_o !== 3'd5 || r_data_o !== 32'h1111_1111) begin
         n_err++; $display("FAIL t1_beat1: got v=%b l=%b id=%0d d=%0h want 10/0/5/11111111", r_valid_o, r_last_o, r_id_o, r_data_o); end
      clk_wait();
      refill_r_last_i = 1'b1; refill_r_data_i = 32'h2222_2222;
      #1;
      n_cmp++; if (r_valid_o !== 2'b10 || r_last_o !== 1'b1 || r_data_o !== 32'h2222_2222) begin
         n_err++; $display("FAIL t1_beat2: got v=%b l=%b d=%0h want 10/1/22222222", r_valid_o, r_last_o, r_data_o); end
      clk_wait();
      refill_r_valid_i = 1'b0; refill_r_last_i = 1'b0;
      req_i = 2'b01; refill_gnt_i = 1'b1;
      count_grants(12, g0, g1);
      n_cmp++; if (g0 != 3 || g1 != 0) begin n_err++; $display("FAIL t1_count: got grants %0d/%0d want 3/0", g0, g1); end
      drive_idle();
   endtask

   task automatic test_same_cycle();
      int g0, g1;
      apply_reset();
      req_i = 2'b01; addr_i[0] = 34'h400; refill_gnt_i = 1'b1;
      count_grants(4, g0, g1);
      n_cmp++; if (g0 != 2) begin n_err++; $display("FAIL same_pre: got %0d want 2", g0); end
      #1;
      n_cmp++; if (gnt_o !== 2'b00) begin n_err++; $display("FAIL same_idle: got %b want 00", gnt_o); end
      clk_wait();
      refill_r_valid_i = 1'b1; refill_r_last_i = 1'b1; refill_r_ID_i = 4'h1;
      #1;
      n_cmp++; if (gnt_o !== 2'b01 || r_valid_o !== 2'b01) begin n_err++; $display("FAIL same_both: got gnt=%b v=%b want 01/01", gnt_o, r_valid_o); end
      clk_wait();
      refill_r_valid_i = 1'b0; refill_r_last_i = 1'b0;
      count_grants(10, g0, g1);
      n_cmp++; if (g0 != 2) begin n_err++; $display("FAIL same_count: got %0d more grants want 2", g0); end
      drive_idle();
   endtask

   task automatic test_reset_mid_issue();
      int g0, g1;
      apply_reset();
      req_i = 2'b11; id_i[0] = 3'd4; id_i[1] = 3'd7; addr_i[0] = 34'h10; addr_i[1] = 34'h20;
      refill_gnt_i = 1'b1;
      count_grants(6, g0, g1);
      refill_gnt_i = 1'b0;
      clk_wait();
      #1;
      n_cmp++; if (refill_req_o !== 1'b1 || refill_ID_o !== 4'b1111) begin
         n_err++; $display("FAIL mid_pre: got req=%b id=%b want 1/1111", refill_req_o, refill_ID_o); end
      rst_ni = 1'b0; refill_gnt_i = 1'b1;
      #1;
      n_cmp++; if (refill_req_o !== 1'b0 || gnt_o !== 2'b00 || refill_addr_o !== 34'h0 || refill_ID_o !== 4'h0 || refill_type_o !== 1'b0) begin
         n_err++; $display("FAIL mid_rst: got req=%b gnt=%b addr=%0h id=%0h type=%b want all 0",
                           refill_req_o, gnt_o, refill_addr_o, refill_ID_o, refill_type_o); end
      clk_wait();
      refill_gnt_i = 1'b0; rst_ni = 1'b1;
      #1;
      n_cmp++; if (refill_req_o !== 1'b0) begin n_err++; $display("FAIL mid_r0: got %b want 0", refill_req_o); end
      clk_wait();
      #1;
      n_cmp++; if (refill_req_o !== 1'b1 || refill_ID_o !== 4'b0100) begin
         n_err++; $display("FAIL mid_r1: got req=%b id=%b want 1/0100", refill_req_o, refill_ID_o); end
      refill_gnt_i = 1'b1;
      count_grants(10, g0, g1);
      n_cmp++; if (g0 + g1 != 4) begin n_err++; $display("FAIL mid_count: got %0d grants want 4", g0 + g1); end
      drive_idle();
   endtask

   function automatic int rr_pick(input int ptr, input logic [NR-1:0] r);
      for (int i = 0; i < NR; i++) begin
         if (r[(ptr + i) % NR]) return (ptr + i) % NR;
      end
      return 0;
   endfunction

   // Randomized traffic against a transaction-level model of arbitration and credit.
   task automatic test_random();
      bit          m_busy, pend[NR], inc, dec;
      int          m_ptr, m_cnt, m_sel, w, idx;
      logic [AW-1:0] m_addr;
      logic        m_type;
      logic [IW-1:0] m_id;
      logic [NR-1:0] exp_gnt, exp_rv;
      bit          exp_req;
      apply_reset();
      m_busy = 0; m_ptr = 0; m_cnt = 0; m_sel = 0; m_addr = '0; m_type = 1'b0; m_id = '0;
      for (int k = 0; k < NR; k++) pend[k] = 0;
      for (int c = 0; c < 3000; c++) begin
         for (int k = 0; k < NR; k++) begin
            if (!pend[k] && $urandom_range(0, 3) == 0) begin
               pend[k] = 1;
               addr_i[k] = AW'({$urandom(), $urandom()});
               type_i[k] = 1'($urandom_range(0, 1));
               id_i[k] = LW'($urandom_range(0, 7));
            end
            req_i[k] = pend[k];
         end
         refill_gnt_i = m_busy && ($urandom_range(0, 2) == 0);
         refill_r_valid_i = ($urandom_range(0, 2) == 0);
         refill_r_last_i = 1'($urandom_range(0, 1));
         refill_r_ID_i = IW'($urandom_range(0, 15));
         refill_r_data_i = $urandom();
         #1;
         exp_req = m_busy && !refill_gnt_i;
         exp_gnt = (m_busy && refill_gnt_i) ? NR'(1 << m_sel) : '0;
         idx = int'(refill_r_ID_i) / (1 << LW);
         exp_rv = (refill_r_valid_i && idx < NR) ? NR'(1 << idx) : '0;
         n_cmp++; if (refill_req_o !== exp_req) begin n_err++; $display("FAIL rnd_req c%0d: got %b want %b", c, refill_req_o, exp_req); end
         n_cmp++; if (gnt_o !== exp_gnt) begin n_err++; $display("FAIL rnd_gnt c%0d: got %b want %b", c, gnt_o, exp_gnt); end
         n_cmp++; if (refill_addr_o !== m_addr || refill_type_o !== m_type || refill_ID_o !== m_id) begin
            n_err++; $display("FAIL rnd_latch c%0d: got %0h/%b/%0h want %0h/%b/%0h", c,
                              refill_addr_o, refill_type_o, refill_ID_o, m_addr, m_type, m_id); end
         n_cmp++; if (r_valid_o !== exp_rv) begin n_err++; $display("FAIL rnd_route c%0d: got %b want %b", c, r_valid_o, exp_rv); end
         n_cmp++; if (r_data_o !== refill_r_data_i || r_last_o !== refill_r_last_i || r_id_o !== refill_r_ID_i[LW-1:0]) begin
            n_err++; $display("FAIL rnd_bcast c%0d: got %0h/%b/%0h", c, r_data_o, r_last_o, r_id_o); end
         for (int k = 0; k < NR; k++) if (exp_gnt[k]) pend[k] = 0;
         inc = m_busy && refill_gnt_i;
         dec = refill_r_valid_i && refill_r_last_i;
         if (inc) begin
            m_busy = 0; m_ptr = (m_sel + 1) % NR;
         end else if (!m_busy && (|req_i) && m_cnt < MO) begin
            w = rr_pick(m_ptr, req_i);
            m_busy = 1; m_sel = w;
            m_addr = addr_i[w]; m_type = type_i[w]; m_id = IW'(w * (1 << LW) + int'(id_i[w]));
         end
         if (inc && !dec) m_cnt++;
         else if (dec && !inc && m_cnt > 0) m_cnt--;
         clk_wait();
      end
      drive_idle();
   endtask

   initial begin
      rst_ni = 1'b0;
      drive_idle();
      test_reset();
      test_single();
      test_rr_alternate();
      test_full_throttle();
      test_type1_routing();
      test_same_cycle();
      test_reset_mid_issue();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
